tcdm_cmd_sched: RTL and testbench

//  Command scheduler in front of tcdm_unit. Arbitrates NB_CH channel command requesters onto the

---
 rtl/tcdm_sched_pkg.sv | 17 +
 rtl/tcdm_rr_arb.sv | 44 ++++
 rtl/tcdm_cmd_sched.sv | 193 +++++++++++++++++++
 tb/tb_tcdm_cmd_sched.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcdm_sched_pkg.sv
// Shared types and constants for the TCDM command scheduler.
package tcdm_sched_pkg;

   localparam int SID_W       = 2;
   localparam int ADD_W       = 12;
   localparam int OPC_W       = 12;
   localparam int LEN_W       = 15;
   localparam int OPC_DIR_BIT = 0;   // opc[OPC_DIR_BIT]=1 -> TX (TCDM read), 0 -> RX (TCDM write)

   typedef struct packed {
      logic [OPC_W-1:0] opc;
      logic [LEN_W-1:0] len;
      logic [ADD_W-1:0] add;
      logic [SID_W-1:0] sid;
   } tcdm_cmd_t;

endpackage

// File: rtl/tcdm_rr_arb.sv
// Round-robin arbiter: one-hot grant to the first requester at/after the pointer,
// pointer advances past the winner only when the caller confirms the grant.
module tcdm_rr_arb #(
   parameter int NB_CH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [NB_CH-1:0] req_i,
   input  logic             en_i,
   output logic [NB_CH-1:0] gnt_o
);

   localparam int PTR_W = (NB_CH > 1) ? $clog2(NB_CH) : 1;

   logic [PTR_W-1:0] ptr_q;
   logic [PTR_W-1:0] ptr_nxt;
   logic             found;
   int               idx;

   // Scan from the pointer with wrap-around and pick the first requester.
   always_comb begin
      gnt_o   = '0;
      ptr_nxt = ptr_q;
      found   = 1'b0;
      idx     = 0;
      for (int i = 0; i < NB_CH; i++) begin
         idx = (int'(ptr_q) + i) % NB_CH;
         if (!found && req_i[idx]) begin
            gnt_o[idx] = 1'b1;
            found      = 1'b1;
            ptr_nxt    = PTR_W'((idx + 1) % NB_CH);
         end
      end
   end

   // Pointer moves only on a confirmed grant.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         ptr_q <= '0;
      else if (en_i && found)
         ptr_q <= ptr_nxt;
   end

endmodule

// File: rtl/tcdm_cmd_sched.sv
// Command scheduler in front of tcdm_unit: arbitrates channel commands onto the TX and
// RX command ports by opcode direction, enforcing a per-SID outstanding limit.
module tcdm_cmd_sched
   import tcdm_sched_pkg::*;
#(
   parameter int NB_CH           = 4,
   parameter int TRANS_SID_WIDTH = SID_W,
   parameter int TCDM_ADD_WIDTH  = ADD_W,
   parameter int TCDM_OPC_WIDTH  = OPC_W,
   parameter int MCHAN_LEN_WIDTH = LEN_W,
   parameter int MAX_OUTST       = 4
) (
   input  logic                                      clk_i,
   input  logic                                      rst_i,
   input  logic [NB_CH-1:0]                          ch_req_i,
   output logic [NB_CH-1:0]                          ch_gnt_o,
   input  logic [NB_CH-1:0][TRANS_SID_WIDTH-1:0]     ch_sid_i,
   input  logic [NB_CH-1:0][TCDM_ADD_WIDTH-1:0]      ch_add_i,
   input  logic [NB_CH-1:0][TCDM_OPC_WIDTH-1:0]      ch_opc_i,
   input  logic [NB_CH-1:0][MCHAN_LEN_WIDTH-1:0]     ch_len_i,
   output logic [TRANS_SID_WIDTH-1:0]                tcdm_tx_sid_o,
   output logic [TCDM_ADD_WIDTH-1:0]                 tcdm_tx_add_o,
   output logic [TCDM_OPC_WIDTH-1:0]                 tcdm_tx_opc_o,
   output logic [MCHAN_LEN_WIDTH-1:0]                tcdm_tx_len_o,
   output logic                                      tcdm_tx_req_o,
   input  logic                                      tcdm_tx_gnt_i,
   output logic [TRANS_SID_WIDTH-1:0]                tcdm_rx_sid_o,
   output logic [TCDM_ADD_WIDTH-1:0]                 tcdm_rx_add_o,
   output logic [TCDM_OPC_WIDTH-1:0]                 tcdm_rx_opc_o,
   output logic [MCHAN_LEN_WIDTH-1:0]                tcdm_rx_len_o,
   output logic                                      tcdm_rx_req_o,
   input  logic                                      tcdm_rx_gnt_i,
   input  logic                                      tx_synch_req_i,
   input  logic [TRANS_SID_WIDTH-1:0]                tx_synch_sid_i,
   input  logic                                      rx_synch_req_i,
   input  logic [TRANS_SID_WIDTH-1:0]                rx_synch_sid_i,
   output logic [(2**TRANS_SID_WIDTH)-1:0]           sid_busy_o,
   output logic                                      err_o
);

   localparam int NB_SID = 2**TRANS_SID_WIDTH;
   localparam int CNT_W  = $clog2(MAX_OUTST + 1);

   logic [CNT_W-1:0] cnt_q   [NB_SID];
   logic [CNT_W-1:0] cnt_nxt [NB_SID];
   int               cnt_sum [NB_SID];
   logic             err_set;

   logic [NB_CH-1:0] lim_ok;
   logic [NB_CH-1:0] tx_elig, rx_elig;
   logic [NB_CH-1:0] tx_win, rx_win;
   logic             tx_acc, rx_acc;
   logic             tx_grant, rx_grant;
   logic             last_slot_clash;
   tcdm_cmd_t        tx_sel, rx_sel;

   tcdm_cmd_t        tx_cmd_p1, rx_cmd_p1;
   logic             vld_tx_p1, vld_rx_p1;

   // Clamp a counter update at zero; an underflow is flagged separately.
   function automatic logic [CNT_W-1:0] sat_cnt(input int sum);
      if (sum < 0)
         return '0;
      else
         return CNT_W'(sum);
   endfunction

   // Eligibility: valid request, matching direction, SID below its limit (registered count).
   always_comb begin
      lim_ok  = '0;
      tx_elig = '0;
      rx_elig = '0;
      for (int c = 0; c < NB_CH; c++) begin
         lim_ok[c]  = (cnt_q[ch_sid_i[c]] < CNT_W'(MAX_OUTST));
         tx_elig[c] = ch_req_i[c] &  ch_opc_i[c][OPC_DIR_BIT] & lim_ok[c];
         rx_elig[c] = ch_req_i[c] & ~ch_opc_i[c][OPC_DIR_BIT] & lim_ok[c];
      end
   end

   tcdm_rr_arb #(.NB_CH(NB_CH)) u_tx_arb (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .req_i (tx_elig),
      .en_i  (tx_grant),
      .gnt_o (tx_win)
   );

   tcdm_rr_arb #(.NB_CH(NB_CH)) u_rx_arb (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .req_i (rx_elig),
      .en_i  (rx_grant),
      .gnt_o (rx_win)
   );

   // Select the payload of each path's one-hot winner.
   always_comb begin
      tx_sel = '0;
      rx_sel = '0;
      for (int c = 0; c < NB_CH; c++) begin
         if (tx_win[c]) begin
            tx_sel.opc = ch_opc_i[c];
            tx_sel.len = ch_len_i[c];
            tx_sel.add = ch_add_i[c];
            tx_sel.sid = ch_sid_i[c];
         end
         if (rx_win[c]) begin
            rx_sel.opc = ch_opc_i[c];
            rx_sel.len = ch_len_i[c];
            rx_sel.add = ch_add_i[c];
            rx_sel.sid = ch_sid_i[c];
         end
      end
   end

   // Grant decision; TX keeps the last free slot when both paths target the same SID.
   always_comb begin
      tx_acc          = ~vld_tx_p1 | tcdm_tx_gnt_i;
      rx_acc          = ~vld_rx_p1 | tcdm_rx_gnt_i;
      tx_grant        = tx_acc & (|tx_win);
      last_slot_clash = tx_grant & (|rx_win) & (tx_sel.sid == rx_sel.sid) &
                        (cnt_q[tx_sel.sid] == CNT_W'(MAX_OUTST - 1));
      rx_grant        = rx_acc & (|rx_win) & ~last_slot_clash;
      ch_gnt_o        = ({NB_CH{tx_grant}} & tx_win) | ({NB_CH{rx_grant}} & rx_win);
   end

   // Outstanding counters: sum of grants and retires per SID, clamped at zero.
   always_comb begin
      err_set = 1'b0;
      for (int s = 0; s < NB_SID; s++) begin
         cnt_sum[s] = int'(cnt_q[s])
                    + int'(tx_grant       && (tx_sel.sid     == TRANS_SID_WIDTH'(s)))
                    + int'(rx_grant       && (rx_sel.sid     == TRANS_SID_WIDTH'(s)))
                    - int'(tx_synch_req_i && (tx_synch_sid_i == TRANS_SID_WIDTH'(s)))
                    - int'(rx_synch_req_i && (rx_synch_sid_i == TRANS_SID_WIDTH'(s)));
         cnt_nxt[s] = sat_cnt(cnt_sum[s]);
         if (cnt_sum[s] < 0)
            err_set = 1'b1;
      end
   end

   // ---- stage p1: command output registers (hold while req high and not accepted) ----
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         vld_tx_p1 <= 1'b0;
         vld_rx_p1 <= 1'b0;
         tx_cmd_p1 <= '0;
         rx_cmd_p1 <= '0;
      end else begin
         if (tx_grant) begin
            vld_tx_p1 <= 1'b1;
            tx_cmd_p1 <= tx_sel;
         end else if (tcdm_tx_gnt_i) begin
            vld_tx_p1 <= 1'b0;
         end
         if (rx_grant) begin
            vld_rx_p1 <= 1'b1;
            rx_cmd_p1 <= rx_sel;
         end else if (tcdm_rx_gnt_i) begin
            vld_rx_p1 <= 1'b0;
         end
      end
   end

   // Counter state, busy flags and sticky underflow error.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int s = 0; s < NB_SID; s++)
            cnt_q[s] <= '0;
         sid_busy_o <= '0;
         err_o      <= 1'b0;
      end else begin
         for (int s = 0; s < NB_SID; s++) begin
            cnt_q[s]      <= cnt_nxt[s];
            sid_busy_o[s] <= (cnt_nxt[s] != '0);
         end
         if (err_set)
            err_o <= 1'b1;
      end
   end

   assign tcdm_tx_req_o = vld_tx_p1;
   assign tcdm_tx_sid_o = tx_cmd_p1.sid;
   assign tcdm_tx_add_o = tx_cmd_p1.add;
   assign tcdm_tx_opc_o = tx_cmd_p1.opc;
   assign tcdm_tx_len_o = tx_cmd_p1.len;
   assign tcdm_rx_req_o = vld_rx_p1;
   assign tcdm_rx_sid_o = rx_cmd_p1.sid;
   assign tcdm_rx_add_o = rx_cmd_p1.add;
   assign tcdm_rx_opc_o = rx_cmd_p1.opc;
   assign tcdm_rx_len_o = rx_cmd_p1.len;

endmodule

// File: tb/tb_tcdm_cmd_sched.sv
// Directed testbench for tcdm_cmd_sched.
module tb_tcdm_cmd_sched;

   localparam int NB_CH = 4;
   localparam int SW    = 2;
   localparam int AW    = 12;
   localparam int OW    = 12;
   localparam int LW    = 15;

   logic                    clk;
   logic                    rst;
   logic [NB_CH-1:0]        ch_req;
   logic [NB_CH-1:0]        ch_gnt;
   logic [NB_CH-1:0][SW-1:0] ch_sid;
   logic [NB_CH-1:0][AW-1:0] ch_add;
   logic [NB_CH-1:0][OW-1:0] ch_opc;
   logic [NB_CH-1:0][LW-1:0] ch_len;
   logic [SW-1:0]           tx_sid, rx_sid;
   logic [AW-1:0]           tx_add, rx_add;
   logic [OW-1:0]           tx_opc, rx_opc;
   logic [LW-1:0]           tx_len, rx_len;
   logic                    tx_req, rx_req;
   logic                    tx_gnt, rx_gnt;
   logic                    tx_synch_req, rx_synch_req;
   logic [SW-1:0]           tx_synch_sid, rx_synch_sid;
   logic [3:0]              sid_busy;
   logic                    err;

   int n_pass;
   int n_total;

   tcdm_cmd_sched #(
      .NB_CH(NB_CH), .TRANS_SID_WIDTH(SW), .TCDM_ADD_WIDTH(AW),
      .TCDM_OPC_WIDTH(OW), .MCHAN_LEN_WIDTH(LW), .MAX_OUTST(4)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .ch_req_i       (ch_req),
      .ch_gnt_o       (ch_gnt),
      .ch_sid_i       (ch_sid),
      .ch_add_i       (ch_add),
      .ch_opc_i       (ch_opc),
      .ch_len_i       (ch_len),
      .tcdm_tx_sid_o  (tx_sid),
      .tcdm_tx_add_o  (tx_add),
      .tcdm_tx_opc_o  (tx_opc),
      .tcdm_tx_len_o  (tx_len),
      .tcdm_tx_req_o  (tx_req),
      .tcdm_tx_gnt_i  (tx_gnt),
      .tcdm_rx_sid_o  (rx_sid),
      .tcdm_rx_add_o  (rx_add),
      .tcdm_rx_opc_o  (rx_opc),
      .tcdm_rx_len_o  (rx_len),
      .tcdm_rx_req_o  (rx_req),
      .tcdm_rx_gnt_i  (rx_gnt),
      .tx_synch_req_i (tx_synch_req),
      .tx_synch_sid_i (tx_synch_sid),
      .rx_synch_req_i (rx_synch_req),
      .rx_synch_sid_i (rx_synch_sid),
      .sid_busy_o     (sid_busy),
      .err_o          (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic clear_inputs();
      ch_req       = '0;
      ch_sid       = '0;
      ch_add       = '0;
      ch_opc       = '0;
      ch_len       = '0;
      tx_synch_req = 1'b0;
      rx_synch_req = 1'b0;
      tx_synch_sid = '0;
      rx_synch_sid = '0;
   endtask

   task automatic set_ch(input int c, input logic req, input logic [SW-1:0] sid,
                         input logic [AW-1:0] add, input logic dir);
      ch_req[c] = req;
      ch_sid[c] = sid;
      ch_add[c] = add;
      ch_opc[c] = {11'h055, dir};
      ch_len[c] = LW'(add) + 15'd1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst    = 1'b1;
      tx_gnt = 1'b1;
      rx_gnt = 1'b1;
      clear_inputs();
      for (int c = 0; c < NB_CH; c++) set_ch(c, 1'b1, SW'(c), AW'(12'h010 + c), 1'b1);
      step();
      n_total++;
      if ({tx_req, rx_req} !== 2'b00) $display("FAIL reset_req: got %b expected 00", {tx_req, rx_req});
      else n_pass++;
      n_total++;
      if ({tx_sid, tx_add, tx_opc, tx_len, rx_sid, rx_add, rx_opc, rx_len} !== '0)
         $display("FAIL reset_payload: got tx_add %h rx_add %h expected 0", tx_add, rx_add);
      else n_pass++;
      n_total++;
      if ({sid_busy, err} !== 5'b0) $display("FAIL reset_busy_err: got %b expected 00000", {sid_busy, err});
      else n_pass++;
      rst = 1'b0;
      settle();
      n_total++;
      if (ch_gnt !== 4'b0001) $display("FAIL reset_first_winner: got %b expected 0001", ch_gnt);
      else n_pass++;
      step();
      n_total++;
      if (tx_req !== 1'b1 || tx_add !== 12'h010) $display("FAIL reset_first_issue: got req %b add %h expected 1 010", tx_req, tx_add);
      else n_pass++;
      tx_gnt = 1'b0;
      step();
      n_total++;
      if (tx_req !== 1'b1 || sid_busy[0] !== 1'b1) $display("FAIL reset_pending: got req %b busy %b expected 1 xxx1", tx_req, sid_busy);
      else n_pass++;
      rst = 1'b1;
      step();
      n_total++;
      if ({tx_req, sid_busy} !== 5'b0) $display("FAIL reset_midop: got %b expected 00000", {tx_req, sid_busy});
      else n_pass++;
      rst = 1'b0;
      clear_inputs();
      tx_gnt = 1'b1;
   endtask

   task automatic test_rr_fairness();
      do_reset();
      tx_gnt = 1'b1;
      for (int c = 0; c < NB_CH; c++) set_ch(c, 1'b1, SW'(c), AW'(12'h100 + c), 1'b1);
      settle();
      for (int i = 0; i < 5; i++) begin
         n_total++;
         if (ch_gnt !== 4'(1 << (i % 4))) $display("FAIL rr_gnt_%0d: got %b expected %b", i, ch_gnt, 4'(1 << (i % 4)));
         else n_pass++;
         step();
         n_total++;
         if (tx_req !== 1'b1 || tx_sid !== SW'(i % 4) || tx_add !== AW'(12'h100 + (i % 4)))
            $display("FAIL rr_issue_%0d: got req %b sid %0d add %h expected 1 %0d %h",
                     i, tx_req, tx_sid, tx_add, i % 4, 12'h100 + (i % 4));
         else n_pass++;
      end
      n_total++;
      if (rx_req !== 1'b0) $display("FAIL rr_rx_idle: got %b expected 0", rx_req);
      else n_pass++;
      clear_inputs();
   endtask

   task automatic test_dual_issue();
      do_reset();
      tx_gnt = 1'b1;
      rx_gnt = 1'b1;
      set_ch(0, 1'b1, 2'd0, 12'h200, 1'b1);
      set_ch(1, 1'b1, 2'd1, 12'h201, 1'b0);
      settle();
      n_total++;
      if (ch_gnt !== 4'b0011) $display("FAIL dual_gnt: got %b expected 0011", ch_gnt);
      else n_pass++;
      step();
      clear_inputs();
      n_total++;
      if ({tx_req, rx_req} !== 2'b11) $display("FAIL dual_req: got %b expected 11", {tx_req, rx_req});
      else n_pass++;
      n_total++;
      if (tx_add !== 12'h200 || rx_add !== 12'h201 || rx_sid !== 2'd1 || rx_len !== 15'h202)
         $display("FAIL dual_payload: got tx %h rx %h sid %0d len %h expected 200 201 1 202", tx_add, rx_add, rx_sid, rx_len);
      else n_pass++;
      step();
   endtask

   task automatic test_back_to_back();
      do_reset();
      tx_gnt = 1'b0;
      set_ch(0, 1'b1, 2'd0, 12'h300, 1'b1);
      settle();
      n_total++;
      if (ch_gnt !== 4'b0001) $display("FAIL bp_first_gnt: got %b expected 0001", ch_gnt);
      else n_pass++;
      step();
      set_ch(0, 1'b1, 2'd0, 12'h301, 1'b1);
      for (int i = 0; i < 5; i++) begin
         settle();
         n_total++;
         if (ch_gnt !== 4'b0000 || tx_req !== 1'b1 || tx_add !== 12'h300 || tx_len !== 15'h301)
            $display("FAIL bp_hold_%0d: got gnt %b req %b add %h expected 0000 1 300", i, ch_gnt, tx_req, tx_add);
         else n_pass++;
         step();
      end
      tx_gnt = 1'b1;
      settle();
      n_total++;
      if (ch_gnt !== 4'b0001) $display("FAIL bp_resume_gnt: got %b expected 0001", ch_gnt);
      else n_pass++;
      step();
      ch_req = '0;
      n_total++;
      if (tx_req !== 1'b1 || tx_add !== 12'h301) $display("FAIL bp_resume_issue: got req %b add %h expected 1 301", tx_req, tx_add);
      else n_pass++;
      step();
      n_total++;
      if (tx_req !== 1'b0) $display("FAIL bp_drain: got %b expected 0", tx_req);
      else n_pass++;
      clear_inputs();
   endtask

   task automatic test_limit();
      do_reset();
      tx_gnt = 1'b1;
      set_ch(0, 1'b1, 2'd1, 12'h400, 1'b1);
      for (int i = 0; i < 4; i++) begin
         settle();
         n_total++;
         if (ch_gnt !== 4'b0001) $display("FAIL limit_gnt_%0d: got %b expected 0001", i, ch_gnt);
         else n_pass++;
         step();
      end
      for (int i = 0; i < 2; i++) begin
         settle();
         n_total++;
         if (ch_gnt !== 4'b0000 || sid_busy[1] !== 1'b1)
            $display("FAIL limit_held_%0d: got gnt %b busy %b expected 0000 xx1x", i, ch_gnt, sid_busy);
         else n_pass++;
         step();
      end
      tx_synch_req = 1'b1;
      tx_synch_sid = 2'd1;
      settle();
      n_total++;
      if (ch_gnt !== 4'b0000) $display("FAIL limit_same_cycle_retire: got %b expected 0000", ch_gnt);
      else n_pass++;
      step();
      tx_synch_req = 1'b0;
      settle();
      n_total++;
      if (ch_gnt !== 4'b0001 || sid_busy[1] !== 1'b1)
         $display("FAIL limit_fifth_gnt: got gnt %b busy %b expected 0001 xx1x", ch_gnt, sid_busy);
      else n_pass++;
      step();
      ch_req = '0;
      n_total++;
      if (tx_req !== 1'b1 || tx_sid !== 2'd1) $display("FAIL limit_fifth_issue: got req %b sid %0d expected 1 1", tx_req, tx_sid);
      else n_pass++;
      clear_inputs();
   endtask

   task automatic test_last_slot();
      do_reset();
      tx_gnt = 1'b1;
      rx_gnt = 1'b1;
      set_ch(0, 1'b1, 2'd3, 12'h500, 1'b1);
      step();
      step();
      step();
      set_ch(1, 1'b1, 2'd3, 12'h501, 1'b0);
      settle();
      n_total++;
      if (ch_gnt !== 4'b0001) $display("FAIL last_slot_gnt: got %b expected 0001", ch_gnt);
      else n_pass++;
      step();
      n_total++;
      if (ch_gnt !== 4'b0000 || rx_req !== 1'b0 || tx_req !== 1'b1)
         $display("FAIL last_slot_full: got gnt %b rx %b tx %b expected 0000 0 1", ch_gnt, rx_req, tx_req);
      else n_pass++;
      clear_inputs();
   endtask

   task automatic test_synch();
      do_reset();
      tx_gnt = 1'b1;
      rx_gnt = 1'b1;
      set_ch(0, 1'b1, 2'd2, 12'h600, 1'b1);
      set_ch(1, 1'b1, 2'd2, 12'h601, 1'b0);
      settle();
      n_total++;
      if (ch_gnt !== 4'b0011) $display("FAIL synch_gnt: got %b expected 0011", ch_gnt);
      else n_pass++;
      step();
      clear_inputs();
      n_total++;
      if (sid_busy !== 4'b0100) $display("FAIL synch_busy_set: got %b expected 0100", sid_busy);
      else n_pass++;
      tx_synch_req = 1'b1;
      tx_synch_sid = 2'd2;
      rx_synch_req = 1'b1;
      rx_synch_sid = 2'd2;
      step();
      clear_inputs();
      n_total++;
      if (sid_busy !== 4'b0000 || err !== 1'b0) $display("FAIL synch_dual_retire: got busy %b err %b expected 0000 0", sid_busy, err);
      else n_pass++;
      tx_synch_req = 1'b1;
      tx_synch_sid = 2'd2;
      step();
      clear_inputs();
      n_total++;
      if (err !== 1'b1 || sid_busy !== 4'b0000) $display("FAIL synch_underflow: got err %b busy %b expected 1 0000", err, sid_busy);
      else n_pass++;
      step();
      step();
      n_total++;
      if (err !== 1'b1) $display("FAIL synch_err_sticky: got %b expected 1", err);
      else n_pass++;
      do_reset();
      n_total++;
      if (err !== 1'b0) $display("FAIL synch_err_reset: got %b expected 0", err);
      else n_pass++;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      test_reset();
      test_rr_fairness();
      test_dual_issue();
      test_back_to_back();
      test_limit();
      test_last_slot();
      test_synch();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
